// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Brief    : Shared Pong definitions: default geometry, state encoding and
//             the signed coordinate/velocity type.
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

    localparam int c_H_ACTIVE       = 1280;
    localparam int c_V_ACTIVE       = 720;
    localparam int c_BALL_SIZE      = 16;
    localparam int c_PADDLE_W       = 16;
    localparam int c_PADDLE_H       = 128;
    localparam int c_PADDLE_SPEED   = 8;
    localparam int c_BALL_SPEED     = 4;
    localparam int c_SCORE_MAX      = 9;
    localparam int c_SERVE_FRAMES   = 60;

    // Paddles sit this far in from the screen edges.
    localparam int c_PADDLE_MARGIN  = 32;
    localparam int c_PADDLE_L_X     = c_PADDLE_MARGIN;
    localparam int c_PADDLE_R_X     = c_H_ACTIVE - c_PADDLE_MARGIN - c_PADDLE_W;
    localparam int c_BALL_CX        = c_H_ACTIVE / 2 - c_BALL_SIZE / 2;
    localparam int c_BALL_CY        = c_V_ACTIVE / 2 - c_BALL_SIZE / 2;
    localparam int c_PADDLE_Y_MAX   = c_V_ACTIVE - c_PADDLE_H;
    localparam int c_PADDLE_CY      = c_PADDLE_Y_MAX / 2;

    typedef logic [1:0] pong_state_t;
    localparam pong_state_t c_ST_IDLE      = 2'd0;
    localparam pong_state_t c_ST_SERVE     = 2'd1;
    localparam pong_state_t c_ST_PLAY      = 2'd2;
    localparam pong_state_t c_ST_GAME_OVER = 2'd3;

    typedef logic signed [12:0] vel_t;

    function automatic vel_t to_s13(input logic [11:0] v);
        return vel_t'({1'b0, v});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_paddle.sv
`default_nettype none
// ============================================================================
//  Module   : pong_paddle
//  Brief    : Combinational paddle mover, one step up or down, clamped.
//  Revision : 1.0  initial release
// ============================================================================
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PADDLE_SPEED = c_PADDLE_SPEED,
    parameter int Y_MAX        = c_PADDLE_Y_MAX
) (
    input  logic [11:0] i_y,
    input  logic        i_up,
    input  logic        i_dn,
    input  logic        i_en,
    output logic [11:0] o_y
);

    localparam vel_t c_STEP = vel_t'(PADDLE_SPEED);
    localparam vel_t c_YMAX = vel_t'(Y_MAX);

    vel_t w_sum;

    always_comb begin
        w_sum = to_s13(i_y);
        if (i_en && i_up && !i_dn) begin
            w_sum = to_s13(i_y) - c_STEP;
        end else if (i_en && i_dn && !i_up) begin
            w_sum = to_s13(i_y) + c_STEP;
        end
        if (w_sum[12]) begin
            o_y = '0;
        end else if (w_sum > c_YMAX) begin
            o_y = c_YMAX[11:0];
        end else begin
            o_y = w_sum[11:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Brief    : Per-frame Pong controller: paddles, ball, collisions, score, FSM.
//             Define PONG_AI_EN to drive the right paddle internally.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = c_H_ACTIVE,
    parameter int V_ACTIVE     = c_V_ACTIVE,
    parameter int BALL_SIZE    = c_BALL_SIZE,
    parameter int PADDLE_W     = c_PADDLE_W,
    parameter int PADDLE_H     = c_PADDLE_H,
    parameter int PADDLE_SPEED = c_PADDLE_SPEED,
    parameter int BALL_SPEED   = c_BALL_SPEED,
    parameter int SCORE_MAX    = c_SCORE_MAX,
    parameter int SERVE_FRAMES = c_SERVE_FRAMES
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        fsync,
    input  logic        start,
    input  logic        btn_l_up,
    input  logic        btn_l_dn,
    input  logic        btn_r_up,
    input  logic        btn_r_dn,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [11:0] paddle_l_y,
    output logic [11:0] paddle_r_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  state,
    output logic        update_done
);

    localparam int          c_CW       = $clog2(SERVE_FRAMES + 1);
    localparam logic [11:0] c_CX       = 12'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [11:0] c_CY       = 12'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [11:0] c_PCY      = 12'((V_ACTIVE - PADDLE_H) / 2);
    localparam int          c_PY_MAX   = V_ACTIVE - PADDLE_H;
    localparam vel_t        c_LX       = vel_t'(c_PADDLE_MARGIN);
    localparam vel_t        c_RX       = vel_t'(H_ACTIVE - c_PADDLE_MARGIN - PADDLE_W);
    localparam vel_t        c_PW       = vel_t'(PADDLE_W);
    localparam vel_t        c_PH       = vel_t'(PADDLE_H);
    localparam vel_t        c_BS       = vel_t'(BALL_SIZE);
    localparam vel_t        c_BY_MAX   = vel_t'(V_ACTIVE - BALL_SIZE);
    localparam vel_t        c_BX_MAX   = vel_t'(H_ACTIVE - BALL_SIZE);
    localparam vel_t        c_SPD      = vel_t'(BALL_SPEED);
    localparam vel_t        c_ZERO     = '0;
    localparam logic [3:0]  c_SMAX     = 4'(SCORE_MAX);
    localparam logic [c_CW-1:0] c_SERVE_CNT = SERVE_FRAMES[c_CW-1:0];
    localparam logic [c_CW-1:0] c_CNT_ONE   = {{(c_CW-1){1'b0}}, 1'b1};

    logic            r_busy;
    logic [1:0]      r_stage;
    vel_t            r_dx, r_dy;
    logic [c_CW-1:0] r_cnt;

    logic [11:0]     r_pl, r_pr;
    vel_t            r_nx, r_ny;
    logic [11:0]     r_bx, r_by;
    vel_t            r_ndx, r_ndy;
    logic [3:0]      r_sl, r_sr;
    pong_state_t     r_st;
    logic [c_CW-1:0] r_ncnt;

    logic            w_move, w_r_up, w_r_dn;
    logic [11:0]     w_pl_next, w_pr_next;

    assign w_move = (state == c_ST_SERVE) || (state == c_ST_PLAY);

`ifdef PONG_AI_EN
    logic [12:0] w_ball_c, w_pad_c;
    logic        w_unused_btn_r;
    assign w_ball_c       = {1'b0, ball_y} + 13'(BALL_SIZE / 2);
    assign w_pad_c        = {1'b0, paddle_r_y} + 13'(PADDLE_H / 2);
    assign w_r_up         = (w_ball_c + 13'd4) < w_pad_c;
    assign w_r_dn         = w_ball_c > (w_pad_c + 13'd4);
    assign w_unused_btn_r = btn_r_up ^ btn_r_dn;
`else
    assign w_r_up = btn_r_up;
    assign w_r_dn = btn_r_dn;
`endif

    pong_paddle #(.PADDLE_SPEED(PADDLE_SPEED), .Y_MAX(c_PY_MAX)) u_paddle_l (
        .i_y  (paddle_l_y),
        .i_up (btn_l_up),
        .i_dn (btn_l_dn),
        .i_en (w_move),
        .o_y  (w_pl_next)
    );

    pong_paddle #(.PADDLE_SPEED(PADDLE_SPEED), .Y_MAX(c_PY_MAX)) u_paddle_r (
        .i_y  (paddle_r_y),
        .i_up (w_r_up),
        .i_dn (w_r_dn),
        .i_en (w_move),
        .o_y  (w_pr_next)
    );

    // Collision and scoring, evaluated on the registered next-ball position.
    logic            w_top, w_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
    logic [11:0]     w_bx, w_by;
    vel_t            w_ndx, w_ndy;
    logic [3:0]      w_sl, w_sr;
    pong_state_t     w_st;
    logic [c_CW-1:0] w_ncnt;

    always_comb begin
        w_top    = (r_ny <= c_ZERO);
        w_bot    = (r_ny >= c_BY_MAX);
        w_hit_l  = r_dx[12] && (r_nx <= c_LX + c_PW) && (r_nx + c_BS > c_LX)
                   && (r_ny + c_BS > to_s13(r_pl)) && (r_ny < to_s13(r_pl) + c_PH);
        w_hit_r  = !r_dx[12] && (r_dx != c_ZERO) && (r_nx + c_BS >= c_RX)
                   && (r_nx < c_RX + c_PW)
                   && (r_ny + c_BS > to_s13(r_pr)) && (r_ny < to_s13(r_pr) + c_PH);
        w_miss_l = !w_hit_l && (r_nx <= c_ZERO);
        w_miss_r = !w_hit_r && (r_nx >= c_BX_MAX);
        w_bx     = ball_x;
        w_by     = ball_y;
        w_ndx    = r_dx;
        w_ndy    = r_dy;
        w_sl     = score_l;
        w_sr     = score_r;
        w_st     = state;
        w_ncnt   = r_cnt;
        case (state)
            c_ST_SERVE: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_ncnt = '0;
                    w_st   = c_ST_PLAY;
                end else begin
                    w_ncnt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_PLAY: begin
                if (w_top) begin
                    w_by  = '0;
                    w_ndy = c_SPD;
                end else if (w_bot) begin
                    w_by  = c_BY_MAX[11:0];
                    w_ndy = -c_SPD;
                end else begin
                    w_by  = r_ny[11:0];
                end
                if (w_hit_l) begin
                    w_bx  = 12'(c_LX + c_PW);
                    w_ndx = c_SPD;
                end else if (w_hit_r) begin
                    w_bx  = 12'(c_RX - c_BS);
                    w_ndx = -c_SPD;
                end else begin
                    w_bx  = r_nx[11:0];
                end
                if (w_miss_l || w_miss_r) begin
                    if (w_miss_l) begin
                        w_sr  = (score_r >= c_SMAX) ? c_SMAX : score_r + 4'd1;
                        w_ndx = -c_SPD;
                    end else begin
                        w_sl  = (score_l >= c_SMAX) ? c_SMAX : score_l + 4'd1;
                        w_ndx = c_SPD;
                    end
                    w_bx   = c_CX;
                    w_by   = c_CY;
                    w_ndy  = c_SPD;
                    w_ncnt = c_SERVE_CNT;
                    w_st   = ((w_sl == c_SMAX) || (w_sr == c_SMAX)) ? c_ST_GAME_OVER : c_ST_SERVE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            ball_x      <= c_CX;
            ball_y      <= c_CY;
            paddle_l_y  <= c_PCY;
            paddle_r_y  <= c_PCY;
            score_l     <= '0;
            score_r     <= '0;
            state       <= c_ST_IDLE;
            update_done <= 1'b0;
            r_dx        <= c_SPD;
            r_dy        <= c_SPD;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_stage     <= '0;
            r_pl        <= c_PCY;
            r_pr        <= c_PCY;
            r_nx        <= '0;
            r_ny        <= '0;
            r_bx        <= c_CX;
            r_by        <= c_CY;
            r_ndx       <= c_SPD;
            r_ndy       <= c_SPD;
            r_sl        <= '0;
            r_sr        <= '0;
            r_st        <= c_ST_IDLE;
            r_ncnt      <= '0;
        end else begin
            update_done <= 1'b0;
            // A start cancels any in-flight update so it cannot overwrite the new game.
            if (start && ((state == c_ST_IDLE) || (state == c_ST_GAME_OVER))) begin
                state   <= c_ST_SERVE;
                r_cnt   <= c_SERVE_CNT;
                r_busy  <= 1'b0;
                r_stage <= '0;
                if (state == c_ST_GAME_OVER) begin
                    score_l <= '0;
                    score_r <= '0;
                    ball_x  <= c_CX;
                    ball_y  <= c_CY;
                end
            end else if (!r_busy) begin
                if (fsync) begin
                    r_busy  <= 1'b1;
                    r_stage <= 2'd0;
                    r_pl    <= w_pl_next;
                    r_pr    <= w_pr_next;
                end
            end else begin
                case (r_stage)
                    2'd0: begin
                        r_nx    <= to_s13(ball_x) + r_dx;
                        r_ny    <= to_s13(ball_y) + r_dy;
                        r_stage <= 2'd1;
                    end
                    2'd1: begin
                        r_bx    <= w_bx;
                        r_by    <= w_by;
                        r_ndx   <= w_ndx;
                        r_ndy   <= w_ndy;
                        r_sl    <= w_sl;
                        r_sr    <= w_sr;
                        r_st    <= w_st;
                        r_ncnt  <= w_ncnt;
                        r_stage <= 2'd2;
                    end
                    default: begin
                        paddle_l_y  <= r_pl;
                        paddle_r_y  <= r_pr;
                        ball_x      <= r_bx;
                        ball_y      <= r_by;
                        r_dx        <= r_ndx;
                        r_dy        <= r_ndy;
                        score_l     <= r_sl;
                        score_r     <= r_sr;
                        state       <= r_st;
                        r_cnt       <= r_ncnt;
                        update_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_stage     <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Brief    : Directed self-checking bench for pong_game_ctrl (default build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1, fsync = 1'b0, start = 1'b0;
    logic        btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [11:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;
    logic        update_done;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .fsync       (fsync),
        .start       (start),
        .btn_l_up    (btn_l_up),
        .btn_l_dn    (btn_l_dn),
        .btn_r_up    (btn_r_up),
        .btn_r_dn    (btn_r_dn),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_y  (paddle_r_y),
        .score_l     (score_l),
        .score_r     (score_r),
        .state       (state),
        .update_done (update_done)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: buttons set, fsync pulse (optionally two cycles long), wait for commit.
    task automatic frame(input logic lu, input logic ld, input logic ru, input logic rd,
                         input bit dbl);
        int n;
        btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
        @(negedge pixel_clk);
        fsync = 1'b1;
        @(negedge pixel_clk);
        n = 0;
        if (dbl) begin
            @(negedge pixel_clk);
            n = 1;
        end
        fsync = 1'b0;
        while (!update_done && n < 16) begin
            @(negedge pixel_clk);
            n++;
        end
        if (!update_done) check_val("update_timeout", 0, 1);
        else              check_val("update_latency", n, 3);
        btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    endtask

    task automatic run(input int cnt, input logic lu, input logic ld,
                       input logic ru, input logic rd);
        for (int i = 0; i < cnt; i++) frame(lu, ld, ru, rd, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge pixel_clk);
        start = 1'b1;
        @(negedge pixel_clk);
        start = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (5) @(negedge pixel_clk);
        rst = 1'b0;
        check_val("rst_ball_x", ball_x, 632);
        check_val("rst_ball_y", ball_y, 352);
        check_val("rst_pad_l", paddle_l_y, 296);
        check_val("rst_pad_r", paddle_r_y, 296);
        check_val("rst_score_l", score_l, 0);
        check_val("rst_score_r", score_r, 0);
        check_val("rst_state", state, 0);
        check_val("rst_done", update_done, 0);

        // IDLE holds positions even with a button pressed
        frame(1, 0, 0, 0, 1'b0);
        check_val("idle_pad_l", paddle_l_y, 296);
        check_val("idle_state", state, 0);

        pulse_start();
        check_val("start_state", state, 1);

        // Serve 1: clamp at top, both-buttons hold, right paddle down to 376
        run(40, 1, 0, 0, 0);
        check_val("clamp_top", paddle_l_y, 0);
        frame(1, 1, 0, 0, 1'b0);
        check_val("both_hold", paddle_l_y, 0);
        run(10, 0, 0, 0, 1);
        check_val("pad_r_down", paddle_r_y, 376);
        run(8, 0, 0, 0, 0);
        check_val("serve59_state", state, 1);
        check_val("serve_ball_x", ball_x, 632);
        check_val("serve_ball_y", ball_y, 352);
        frame(0, 0, 0, 0, 1'b0);
        check_val("serve60_state", state, 2);

        // Play 1: bottom wall bounce, right paddle hit, left miss
        run(87, 0, 0, 0, 0);
        check_val("k87_x", ball_x, 980);
        check_val("k87_y", ball_y, 700);
        frame(0, 0, 0, 0, 1'b0);
        check_val("wall_x", ball_x, 984);
        check_val("wall_y", ball_y, 704);
        frame(0, 0, 0, 0, 1'b0);
        check_val("wall_back_y", ball_y, 700);
        run(56, 0, 0, 0, 0);
        check_val("k145_x", ball_x, 1212);
        frame(0, 0, 0, 0, 1'b0);
        check_val("rhit_x", ball_x, 1216);
        check_val("rhit_y", ball_y, 472);
        frame(0, 0, 0, 0, 1'b0);
        check_val("rhit_back_x", ball_x, 1212);
        check_val("rhit_back_y", ball_y, 468);
        run(302, 0, 0, 0, 0);
        check_val("k449_x", ball_x, 4);
        check_val("k449_score_r", score_r, 0);
        frame(0, 0, 0, 0, 1'b0);
        check_val("miss_score_r", score_r, 1);
        check_val("miss_score_l", score_l, 0);
        check_val("miss_ball_x", ball_x, 632);
        check_val("miss_ball_y", ball_y, 352);
        check_val("miss_state", state, 1);

        // Serve 2: second fsync cycle while busy is ignored
        frame(0, 1, 0, 0, 1'b1);
        check_val("dbl_fsync_pad", paddle_l_y, 8);
        run(59, 0, 1, 0, 0);
        check_val("pad_l_480", paddle_l_y, 480);
        check_val("serve2_state", state, 2);

        // Play 2: ball serves left, hits left paddle at 480, right misses
        run(145, 0, 0, 0, 0);
        check_val("lhit_pre_x", ball_x, 52);
        check_val("lhit_pre_y", ball_y, 476);
        frame(0, 0, 0, 0, 1'b0);
        check_val("lhit_x", ball_x, 48);
        check_val("lhit_y", ball_y, 472);
        frame(0, 0, 0, 0, 1'b0);
        check_val("lhit_back_x", ball_x, 52);
        run(302, 0, 0, 0, 0);
        check_val("k449b_x", ball_x, 1260);
        frame(0, 0, 0, 0, 1'b0);
        check_val("rmiss_score_l", score_l, 1);
        check_val("rmiss_score_r", score_r, 1);
        check_val("rmiss_state", state, 1);

        // Right paddle to the top so every later serve misses on the right
        run(60, 0, 0, 1, 0);
        check_val("pad_r_top", paddle_r_y, 0);
        check_val("serve3_state", state, 2);
        run(158, 0, 0, 0, 0);
        check_val("rally_score_2", score_l, 2);
        for (int s = 3; s <= 9; s++) begin
            run(60, 0, 0, 0, 0);
            run(158, 0, 0, 0, 0);
            check_val("rally_score", score_l, s);
        end
        check_val("go_state", state, 3);
        check_val("go_ball_x", ball_x, 632);
        check_val("go_ball_y", ball_y, 352);

        // GAME_OVER freezes everything
        frame(0, 1, 0, 1, 1'b0);
        check_val("go_pad_l", paddle_l_y, 480);
        check_val("go_pad_r", paddle_r_y, 0);
        check_val("go_hold_state", state, 3);

        pulse_start();
        check_val("restart_state", state, 1);
        check_val("restart_score_l", score_l, 0);
        check_val("restart_score_r", score_r, 0);
        run(59, 0, 0, 0, 0);
        check_val("restart59_state", state, 1);
        frame(0, 0, 0, 0, 1'b0);
        check_val("restart60_state", state, 2);

        // Reset in the middle of an update aborts it
        @(negedge pixel_clk);
        fsync = 1'b1;
        @(negedge pixel_clk);
        fsync = 1'b0;
        @(negedge pixel_clk);
        rst = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge pixel_clk);
            if (update_done) seen = 1;
        end
        check_val("abort_done", seen, 0);
        check_val("abort_state", state, 0);
        check_val("abort_pad_l", paddle_l_y, 296);

        // Reset dominates start in the same cycle
        @(negedge pixel_clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
        start = 1'b0;
        check_val("rst_over_start", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
